// File: rtl/data_in_transfer.sv
// Inbound AXI read-data stage: packs 32-bit beat pairs into 64-bit words and
// writes them into the feature-map BRAM banks, then pulses stage_done.
module data_in_transfer #(
   parameter int unsigned DATA_NUM      = 192,
   parameter int unsigned ROWS_PER_BANK = 4,
   parameter int unsigned BANK_NUM      = 16,
   parameter int unsigned ADDR_W        = 14
) (
   input  logic                axi_ACLK,
   input  logic                axi_ARESETN,
   input  logic                stage_start,
   input  logic [31:0]         read_data,
   input  logic                read_valid,
   output logic                read_ready,
   output logic [BANK_NUM-1:0] bram_ena,
   output logic [BANK_NUM-1:0] bram_wea,
   output logic [ADDR_W-1:0]   bram_addra,
   output logic [63:0]         bram_dina,
   output logic                stage_done
);

   localparam int unsigned TOTAL_ROWS = BANK_NUM * ROWS_PER_BANK;
   localparam int unsigned WORD_W     = $clog2(DATA_NUM + 1);
   localparam int unsigned ROW_W      = $clog2(TOTAL_ROWS + 1);
   localparam int unsigned BANK_W     = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RECV = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]          r_state;
   logic [1:0]          w_next_state;
   logic                r_start_ff;
   logic                r_read_ready;
   logic                r_done;
   logic                r_half;
   logic [31:0]         r_low;
   logic [WORD_W-1:0]   r_word_cnt;
   logic [ROW_W-1:0]    r_row_cnt;
   logic [BANK_NUM-1:0] r_ena;
   logic [ADDR_W-1:0]   r_addr;
   logic [63:0]         r_din;

   logic                w_start_pulse;
   logic                w_accept;
   logic                w_word_last;
   logic                w_last_pair;
   logic [BANK_W-1:0]   w_bank;
   logic [ADDR_W-1:0]   w_addr;

   assign w_start_pulse = stage_start & ~r_start_ff;
   assign w_accept      = read_valid & r_read_ready;
   assign w_word_last   = (r_word_cnt == WORD_W'(DATA_NUM - 1));
   assign w_last_pair   = w_accept & r_half & w_word_last &
                          (r_row_cnt == ROW_W'(TOTAL_ROWS - 1));

   // Row-to-bank mapping shared with the outbound transfer stage
   assign w_bank = BANK_W'(32'(r_row_cnt) / ROWS_PER_BANK);
   assign w_addr = ADDR_W'((32'(r_row_cnt) % ROWS_PER_BANK) * DATA_NUM + 32'(r_word_cnt));

   always_ff @(posedge axi_ACLK or negedge axi_ARESETN) begin
      if (!axi_ARESETN) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // A start edge restarts the frame from any state
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_start_pulse) w_next_state = S_RECV;
         end
         S_RECV: begin
            if (w_start_pulse)    w_next_state = S_RECV;
            else if (w_last_pair) w_next_state = S_DONE;
         end
         S_DONE: begin
            w_next_state = w_start_pulse ? S_RECV : S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge axi_ACLK or negedge axi_ARESETN) begin
      if (!axi_ARESETN) begin
         r_start_ff   <= 1'b0;
         r_read_ready <= 1'b0;
         r_done       <= 1'b0;
         r_half       <= 1'b0;
         r_low        <= '0;
         r_word_cnt   <= '0;
         r_row_cnt    <= '0;
         r_ena        <= '0;
         r_addr       <= '0;
         r_din        <= '0;
      end else begin
         r_start_ff   <= stage_start;
         r_read_ready <= (w_next_state == S_RECV);
         r_done       <= (w_next_state == S_DONE);
         r_ena        <= '0;
         if (w_start_pulse) begin
            r_half     <= 1'b0;
            r_word_cnt <= '0;
            r_row_cnt  <= '0;
         end else if (w_accept) begin
            if (!r_half) begin
               r_low  <= read_data;
               r_half <= 1'b1;
            end else begin
               r_half <= 1'b0;
               r_ena  <= BANK_NUM'(1) << w_bank;
               r_addr <= w_addr;
               r_din  <= {read_data, r_low};
               if (w_word_last) begin
                  r_word_cnt <= '0;
                  r_row_cnt  <= r_row_cnt + ROW_W'(1);
               end else begin
                  r_word_cnt <= r_word_cnt + WORD_W'(1);
               end
            end
         end
      end
   end

   assign read_ready = r_read_ready;
   assign stage_done = r_done;
   assign bram_ena   = r_ena;
   assign bram_wea   = r_ena;
   assign bram_addra = r_addr;
   assign bram_dina  = r_din;

endmodule
